// File: rtl/memsplit_copy_master.sv
// rtl/memsplit_copy_master.sv - MemSplit32 word-copy master (read word, write word, repeat).
// Optional read-response watchdog enabled by defining MEMSPLIT_COPY_TIMEOUT_EN.
module memsplit_copy_master #(
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_bi,
  input  logic [31:0]          dst_addr_bi,
  input  logic [LEN_WIDTH-1:0] len_bi,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [31:0]          bus_addr,
  output logic [3:0]           bus_be,
  output logic [31:0]          bus_wdata,
  input  logic                 bus_ack,
  input  logic                 bus_resp,
  input  logic [31:0]          bus_rdata
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

  state_t               state;
  logic [31:0]          src;
  logic [31:0]          dst;
  logic [LEN_WIDTH-1:0] count;

  assign busy_o = (state != IDLE);

`ifdef MEMSPLIT_COPY_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd;
  logic            err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Each request state spends its first cycle raising req; the handshake is
  // only recognised once the registered req is visible to the slave.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      done_o    <= 1'b0;
      src       <= 32'h0;
      dst       <= 32'h0;
      count     <= '0;
`ifdef MEMSPLIT_COPY_TIMEOUT_EN
      wd        <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            src   <= src_addr_bi;
            dst   <= dst_addr_bi;
            count <= len_bi;
`ifdef MEMSPLIT_COPY_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            state <= (len_bi == '0) ? DONE : RD_REQ;
          end
        end
        RD_REQ: begin
          if (bus_req && bus_ack) begin
            bus_req <= 1'b0;
            state   <= RD_WAIT;
`ifdef MEMSPLIT_COPY_TIMEOUT_EN
            wd      <= '0;
`endif
          end else begin
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= src;
            bus_be   <= 4'hF;
          end
        end
        RD_WAIT: begin
          if (bus_resp) begin
            bus_wdata <= bus_rdata;
            state     <= WR_REQ;
          end
`ifdef MEMSPLIT_COPY_TIMEOUT_EN
          else if (wd == WD_LAST) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        WR_REQ: begin
          if (bus_req && bus_ack) begin
            bus_req <= 1'b0;
            src     <= src + 32'd4;
            dst     <= dst + 32'd4;
            count   <= count - 1'b1;
            state   <= (count == LEN_WIDTH'(1)) ? DONE : RD_REQ;
          end else begin
            bus_req  <= 1'b1;
            bus_we   <= 1'b1;
            bus_addr <= dst;
            bus_be   <= 4'hF;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memsplit_copy_master.sv
// tb/tb_memsplit_copy_master.sv - self-checking bench for memsplit_copy_master.
// Watchdog checks are compiled in when MEMSPLIT_COPY_TIMEOUT_EN is defined.
module tb_memsplit_copy_master;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] src_addr_bi = 32'h0;
  logic [31:0] dst_addr_bi = 32'h0;
  logic [15:0] len_bi = 16'h0;
  logic        busy_o, done_o, err_o;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic        bus_resp = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  memsplit_copy_master #(.LEN_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .src_addr_bi(src_addr_bi), .dst_addr_bi(dst_addr_bi), .len_bi(len_bi),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_resp(bus_resp), .bus_rdata(bus_rdata)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } txn_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          ack_delay;
    int          resp_lat;
    bit          glitch;
    int          exp_lat;
  } vec_t;

  txn_t        log_q[$];
  int          ack_delay = 0;
  int          resp_lat = 1;
  bit          resp_en = 1'b1;
  int          ack_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] resp_data = 32'h0;
  bit          prev_wait = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] prev_wdata = 32'h0;
  logic [3:0]  prev_be = 4'h0;
  int          stab_viol = 0;
  int          req_cycles = 0;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slave model: ack after ack_delay cycles of req, read data resp_lat cycles later.
  always @(negedge clk) begin
    bus_resp = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0 && resp_en) begin
        bus_resp  = 1'b1;
        bus_rdata = resp_data;
      end
    end
    if (rst_i) begin
      ack_cnt   = 0;
      bus_ack   = 1'b0;
      prev_wait = 1'b0;
      resp_cnt  = 0;
    end else begin
      if (bus_req) req_cycles++;
      if (prev_wait && bus_req &&
          (bus_addr != prev_addr || bus_we != prev_we || bus_wdata != prev_wdata || bus_be != prev_be))
        stab_viol++;
      bus_ack = bus_req && (ack_cnt >= ack_delay);
      if (bus_ack) begin
        log_q.push_back(txn_t'{bus_we, bus_addr, bus_wdata, bus_be});
        if (!bus_we) begin
          resp_cnt  = resp_lat;
          resp_data = src_word(bus_addr);
        end
        ack_cnt = 0;
      end else if (bus_req) begin
        ack_cnt++;
      end else begin
        ack_cnt = 0;
      end
      prev_wait  = bus_req && !bus_ack;
      prev_we    = bus_we;
      prev_addr  = bus_addr;
      prev_wdata = bus_wdata;
      prev_be    = bus_be;
    end
  end

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
    @(negedge clk);
    start_i = 1'b1;
    src_addr_bi = s;
    dst_addr_bi = d;
    len_bi = 16'(n);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    src_addr_bi = $urandom;
    dst_addr_bi = $urandom;
    len_bi = 16'($urandom);
  endtask

  task automatic run_copy(input vec_t v);
    int          lat;
    bit          seen;
    int          base;
    int          rc0;
    logic [31:0] sa;
    logic [31:0] da;
    ack_delay = v.ack_delay;
    resp_lat  = v.resp_lat;
    resp_en   = 1'b1;
    stab_viol = 0;
    base = log_q.size();
    rc0  = req_cycles;
    pulse_start(v.src, v.dst, v.len);
    lat  = 1;
    seen = 1'b0;
    while (lat < 3000) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (v.glitch && lat == 3) start_i = 1'b1;
      if (v.glitch && lat == 4) start_i = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("done_latency", seen ? lat : -1, v.exp_lat);
    check("err_after_copy", err_o, 0);
    @(negedge clk);
    check("done_one_cycle", done_o, 0);
    check("idle_after_done", busy_o, 0);
    check("txn_count", log_q.size() - base, 2 * v.len);
    check("req_stable", stab_viol, 0);
    if (v.len == 0) check("no_req_len0", req_cycles - rc0, 0);
    for (int i = 0; i < v.len; i++) begin
      sa = v.src + 32'(4 * i);
      da = v.dst + 32'(4 * i);
      if (base + 2 * i + 1 < log_q.size()) begin
        check("rd_we", log_q[base + 2 * i].we, 0);
        check("rd_addr", log_q[base + 2 * i].addr, sa);
        check("rd_be", log_q[base + 2 * i].be, 4'hF);
        check("wr_we", log_q[base + 2 * i + 1].we, 1);
        check("wr_addr", log_q[base + 2 * i + 1].addr, da);
        check("wr_data", log_q[base + 2 * i + 1].data, src_word(sa));
        check("wr_be", log_q[base + 2 * i + 1].be, 4'hF);
      end
    end
  endtask

  vec_t vecs[5];

  initial begin
    int          lat;
    bit          seen;
    int          n0;
    int          rc0;
    vec_t        rv;
    logic [31:0] r;

    // {src, dst, len, ack_delay, resp_lat, glitch, expected done latency}
    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 1, 0, 1, 1'b0, 7};
    vecs[1] = '{32'h0000_1000, 32'h0000_2000, 4, 0, 1, 1'b0, 22};
    vecs[2] = '{32'h0000_0500, 32'h0000_0600, 0, 0, 1, 1'b0, 2};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0000_8000, 2, 3, 1, 1'b1, 24};
    vecs[4] = '{32'h0000_3000, 32'h0000_4000, 3, 1, 2, 1'b0, 26};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    check("reset_req", bus_req, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_err", err_o, 0);

    for (int i = 0; i < 5; i++) run_copy(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      rv.src = {r[31:2], 2'b00};
      r = $urandom;
      rv.dst = {r[31:2], 2'b00};
      rv.len = $urandom_range(1, 5);
      rv.ack_delay = $urandom_range(0, 2);
      rv.resp_lat = $urandom_range(1, 3);
      rv.glitch = 1'(i % 2);
      rv.exp_lat = 2 + rv.len * (4 + 2 * rv.ack_delay + rv.resp_lat);
      run_copy(rv);
    end

    // Reset in the middle of a four-word copy.
    ack_delay = 0;
    resp_lat = 1;
    resp_en = 1'b1;
    pulse_start(32'h0000_7000, 32'h0000_9000, 4);
    repeat (7) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check("midrst_req", bus_req, 0);
    check("midrst_busy", busy_o, 0);
    rst_i = 1'b0;
    n0 = log_q.size();
    rc0 = req_cycles;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("midrst_no_done", seen, 0);
    check("midrst_no_traffic", log_q.size() - n0, 0);
    check("midrst_no_req", req_cycles - rc0, 0);

    // Slave never responds to the read.
    resp_en = 1'b0;
    pulse_start(32'h0000_0A00, 32'h0000_0B00, 2);
`ifdef MEMSPLIT_COPY_TIMEOUT_EN
    lat = 1;
    seen = 1'b0;
    while (lat < 200) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    check("wd_done_latency", seen ? lat : -1, 12);
    check("wd_err_set", err_o, 1);
    @(negedge clk);
    check("wd_idle", busy_o, 0);
    check("wd_err_sticky", err_o, 1);
    check("wd_one_write_less", log_q[log_q.size() - 1].we, 0);
    rv = '{32'h0000_0C00, 32'h0000_0D00, 1, 0, 1, 1'b0, 7};
    run_copy(rv);
`else
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("stall_busy", busy_o, 1);
    check("stall_no_done", seen, 0);
    check("stall_err", err_o, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    check("stall_reset_idle", busy_o, 0);
    rv = '{32'h0000_0C00, 32'h0000_0D00, 1, 0, 1, 1'b0, 7};
    run_copy(rv);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memsplit_copy_master.md
Name: memsplit_copy_master

Overview:
- Word-copy engine acting as initiator (master) on a MemSplit32 bus; the bus-side counterpart of the tile's slave peripherals such as SFR and RAM.
- Local logic provides source, destination and word count. The block then issues alternating read/write transactions, one word at a time, until the count is exhausted.
- Sits in sigma_tile next to the core's data port and reaches slaves through the tile interconnect.

Parameters:
- LEN_WIDTH, 16, width of the word-count input and internal down-counter.
- TIMEOUT_CYCLES, 255, read-response watchdog limit in clk_i cycles (used only with MEMSPLIT_COPY_TIMEOUT_EN).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  one-cycle start strobe; sampled only in IDLE.
- src_addr_bi  input  32  source byte address; captured on accepted start.
- dst_addr_bi  input  32  destination byte address; captured on accepted start.
- len_bi  input  LEN_WIDTH  number of 32-bit words; captured on accepted start.
- busy_o  output  1  high while not IDLE.
- done_o  output  1  one-cycle pulse on completion.
- err_o  output  1  sticky abort flag; cleared by next accepted start.
- bus  MemSplit32.Master  —  req, we, addr[31:0], be[3:0], wdata[31:0] out; ack, resp, rdata[31:0] in.

Behaviour:
- Clock and reset: clk_i is the only clock. rst_i is synchronous and active-high, and wins over every other input.
- Reset values: state=IDLE, bus.req=0, bus.we=0, bus.addr=0, bus.be=0, bus.wdata=0, busy_o=0, done_o=0, err_o=0, counter=0.
- Bus rule (request phase):
  - req and its addr/we/be/wdata are registered and held stable until a cycle with req=1 and ack=1.
  - req drops in the cycle after that handshake.
- Bus rule (read response):
  - Reads complete on a later cycle with resp=1; rdata is valid in that cycle.
  - At most one read is outstanding.
  - resp outside RD_WAIT is ignored.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - start_i=1 latches src/dst/len and clears err_o.
  - len=0 → DONE directly, with no bus traffic.
  - Otherwise → RD_REQ.
- RD_REQ: req=1, we=0, addr=src, be=4'hF. Handshake → RD_WAIT.
- RD_WAIT: resp=1 captures rdata into wdata and goes to WR_REQ.
- WR_REQ: req=1, we=1, addr=dst, be=4'hF. On handshake:
  - src += 4, dst += 4, counter -= 1.
  - counter was 1 → DONE; otherwise → RD_REQ.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Latency: with ack=req and resp one cycle after a read handshake, a word costs 5 cycles. Measured from start_i, done_o rises after 5·N+2 cycles.
- Address arithmetic: 32-bit, wraps 0xFFFFFFFC → 0x00000000 with no error.
- start_i while busy: ignored; latched parameters are not disturbed.
- ack held permanently low: master stalls in RD_REQ/WR_REQ indefinitely. No timeout applies in the request phase.
- resp in the same cycle as the read handshake: not possible per protocol. The master does not sample resp in RD_REQ.
- Reset mid-transfer: returns to IDLE and drops req in the next cycle. No done_o pulse is produced, and no partial write is replayed.

Optional Feature:
- Macro: MEMSPLIT_COPY_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in RD_WAIT.
  - If TIMEOUT_CYCLES cycles elapse without resp, err_o is set and the FSM goes to DONE; done_o still pulses.
  - The remaining words are abandoned.
  - A late resp arriving after the abort is ignored.
- Not defined: no watchdog; RD_WAIT waits forever; err_o is tied 0.

Test Plan:
- Reset: rst_i high 3 cycles, then low → req=0, busy_o=0, done_o=0, err_o=0.
- Single-word copy:
  - Setup: src=0x100, dst=0x200, len=1; slave with ack=req, resp 1 cycle later, rdata=0xDEADBEEF.
  - Expect: read at 0x100, then write 0x200 with wdata=0xDEADBEEF, be=F; done_o 7 cycles after start.
- Four-word copy: src=0x1000, dst=0x2000, len=4.
  - Write addresses: 0x2000, 0x2004, 0x2008, 0x200C, with data matching the source model.
  - done_o at cycle 22.
- Zero length: len=0 → no req ever asserted; done_o pulses 2 cycles after start.
- Boundary and stress: src=0xFFFFFFFC, len=2.
  - Second read addresses 0x00000000.
  - Slave delays ack by 3 cycles per transaction → addr/we/wdata remain stable while req is high.
  - start_i pulsed mid-transfer is ignored.
  - rst_i mid-transfer → IDLE next cycle, req=0.
- Watchdog (MEMSPLIT_COPY_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never asserts resp.
  - Expect err_o=1 and done_o pulse after 8 RD_WAIT cycles.
  - Next start clears err_o.
